manchester_serial_to_nibble_sm: RTL and testbench
=================================================

Name: manchester_serial_to_nibble_sm

Overview:
Receive-side counterpart of the transmit nibble-to-serial state machine. It consumes recovered NRZ bits and per-bit centre-sample strobes from the Manchester decoder adapter, hunts preamble/SFD, and assembles LSB-first bits into nibbles. Output is an MII-style receive nibble stream with dv/er, plus packet-level status and saturating debug counters. It sits inside the Manchester decoder, between the decoder adapter and the MAC MII receive path.

Parameters:
MIN_PREAMBLE_BITS, 16, alternating bits required before an SFD "11" is accepted
SFD_TIMEOUT_BITS, 256, preamble bits allowed without SFD before timeout
MAX_NIBBLES, 3044, data nibbles per frame before a jabber abort (1522 bytes)
CNT_W, 16, width of the status counters

Ports:
clk16x  input  1  16x bit-rate clock; the only clock
reset  input  1  synchronous, active-high reset
irx_center_sample  input  1  one-cycle strobe; nrz_data is valid this cycle
inrz_data  input  1  recovered NRZ bit
idle_line  input  1  line idle (level); ends a packet
reset_all_pkt_cntrs  input  1  synchronous clear of all counters
rx_nibble  output  4  assembled nibble, bit0 = first bit received
rx_nibble_valid  output  1  one-cycle strobe, rx_nibble valid
rx_dv  output  1  high from SFD accept to packet end/abort
rx_er  output  1  one-cycle error strobe (dribble, jabber)
rx_packet_end  output  1  one-cycle strobe at end of any frame that reached DATA
sfd_timeout  output  1  one-cycle strobe on SFD timeout
missed_sfd_flag  output  1  sticky; set on timeout, cleared by reset_all_pkt_cntrs
rx_state  output  3  current state encoding, debug
pkt_cnt  output  CNT_W  good packets, saturating
err_cnt  output  CNT_W  rx_er events, saturating
sfd_miss_cnt  output  CNT_W  SFD timeouts, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; shift register and bit counters 0.
- States: IDLE=0, PREAMBLE=1, DATA=2, WAIT_IDLE=3.
- Priority, highest first: reset, idle_line, irx_center_sample.
- IDLE: first irx_center_sample with idle_line=0 -> PREAMBLE, pre_cnt=1, last_bit=inrz_data.
- PREAMBLE, on each sample:
  - bit != last_bit: pre_cnt++.
  - "00": pre_cnt=1; stay.
  - "11" with pre_cnt >= MIN_PREAMBLE_BITS: SFD accepted -> DATA; rx_dv=1 the next cycle.
  - "11" with pre_cnt < MIN_PREAMBLE_BITS: pre_cnt=1; stay.
  - pre_cnt reaches SFD_TIMEOUT_BITS: sfd_timeout pulse, missed_sfd_flag=1, sfd_miss_cnt++ -> WAIT_IDLE.
  - idle_line in PREAMBLE: -> IDLE silently; no rx_packet_end.
- DATA:
  - Each sample shifts the bit in LSB-first (bit k of nibble = k-th bit).
  - 4th bit: rx_nibble/rx_nibble_valid registered on the cycle after that strobe (latency 1); nib_cnt++.
  - nib_cnt reaching MAX_NIBBLES on a nibble: that nibble is still output; next cycle rx_er pulse, rx_dv=0, rx_packet_end pulse, err_cnt++ -> WAIT_IDLE.
  - idle_line with bit_in_nibble==0: rx_dv=0 and rx_packet_end pulse next cycle, pkt_cnt++ -> IDLE.
  - idle_line with bit_in_nibble!=0: partial nibble discarded; rx_er and rx_packet_end pulse, rx_dv=0, err_cnt++ -> IDLE.
- WAIT_IDLE: ignore samples; idle_line -> IDLE.
- Strobe in the same cycle as idle_line: sample discarded.
- rx_dv stays high through the final nibble strobe and falls together with rx_packet_end.
- Counters saturate at all-ones.
- reset_all_pkt_cntrs: clears counters and missed_sfd_flag; beats any same-cycle increment; does not affect state or rx_dv.
- Reset mid-frame: immediate return to IDLE; no end/er strobes generated.

Test Plan:
- 16 alternating bits (1,0,...) + "11" + data bytes 0xA5, 0x3C LSB-first, then idle_line -> rx_nibble 5, A, C, 3 with 4 strobes; rx_dv high across them; rx_packet_end once; pkt_cnt=1; rx_er never.
- 8 alternating bits + "11", then 16 alternating + "11" + 0x0F -> first "11" ignored; frame accepted; nibbles F, 0.
- 256 alternating bits, no SFD -> sfd_timeout pulse at bit 256; missed_sfd_flag=1; sfd_miss_cnt=1; no rx_dv until idle_line then new frame.
- Valid SFD + 6 data bits + idle_line -> one nibble strobe; rx_er pulse; rx_packet_end pulse; err_cnt=1; pkt_cnt=0.
- MAX_NIBBLES=8 override, SFD + 40 data bits -> exactly 8 nibble strobes; rx_er and rx_dv fall the cycle after the 8th; remaining bits ignored until idle_line.
- Drive err_cnt to 0xFFFF and confirm it saturates; assert reset_all_pkt_cntrs in the same cycle as a packet end -> all counters 0 and missed_sfd_flag 0 next cycle.

Source files
------------

// File: rtl/manchester_serial_to_nibble_sm.sv
// Receive nibble assembler for the Manchester decoder: hunts preamble/SFD on recovered
// NRZ bits, packs LSB-first bits into nibbles and drives an MII-style rx stream with
// packet status and saturating debug counters.
module manchester_serial_to_nibble_sm #(
    parameter int unsigned MIN_PREAMBLE_BITS = 16,
    parameter int unsigned SFD_TIMEOUT_BITS  = 256,
    parameter int unsigned MAX_NIBBLES       = 3044,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk16x,
    input  logic             reset,
    input  logic             irx_center_sample,
    input  logic             inrz_data,
    input  logic             idle_line,
    input  logic             reset_all_pkt_cntrs,
    output logic [3:0]       rx_nibble,
    output logic             rx_nibble_valid,
    output logic             rx_dv,
    output logic             rx_er,
    output logic             rx_packet_end,
    output logic             sfd_timeout,
    output logic             missed_sfd_flag,
    output logic [2:0]       rx_state,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sfd_miss_cnt
);

    localparam int unsigned PreW = $clog2(SFD_TIMEOUT_BITS + 1);
    localparam int unsigned NibW = $clog2(MAX_NIBBLES + 1);
    localparam logic [PreW-1:0] PreMin  = PreW'(MIN_PREAMBLE_BITS);
    localparam logic [PreW-1:0] PreLast = PreW'(SFD_TIMEOUT_BITS - 1);
    localparam logic [NibW-1:0] NibLast = NibW'(MAX_NIBBLES - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPreamble = 3'd1,
        StData     = 3'd2,
        StWaitIdle = 3'd3
    } state_e;

    state_e           state_q;
    logic [PreW-1:0]  pre_cnt_q;
    logic             last_bit_q;
    logic [2:0]       shreg_q;
    logic [1:0]       bit_cnt_q;
    logic [NibW-1:0]  nib_cnt_q;
    logic             jab_pend_q;
    logic [3:0]       rx_nibble_q;
    logic             rx_nibble_valid_q;
    logic             rx_dv_q;
    logic             rx_er_q;
    logic             rx_packet_end_q;
    logic             sfd_timeout_q;
    logic             missed_sfd_q;
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] sfd_miss_cnt_q;

    // Receive FSM with registered outputs and counters.
    always_ff @(posedge clk16x) begin
        if (reset) begin
            state_q           <= StIdle;
            pre_cnt_q         <= '0;
            last_bit_q        <= 1'b0;
            shreg_q           <= '0;
            bit_cnt_q         <= '0;
            nib_cnt_q         <= '0;
            jab_pend_q        <= 1'b0;
            rx_nibble_q       <= '0;
            rx_nibble_valid_q <= 1'b0;
            rx_dv_q           <= 1'b0;
            rx_er_q           <= 1'b0;
            rx_packet_end_q   <= 1'b0;
            sfd_timeout_q     <= 1'b0;
            missed_sfd_q      <= 1'b0;
            pkt_cnt_q         <= '0;
            err_cnt_q         <= '0;
            sfd_miss_cnt_q    <= '0;
        end else begin
            rx_nibble_valid_q <= 1'b0;
            rx_er_q           <= 1'b0;
            rx_packet_end_q   <= 1'b0;
            sfd_timeout_q     <= 1'b0;
            jab_pend_q        <= 1'b0;

            // Jabber abort lands one cycle after the final nibble so that nibble keeps rx_dv.
            if (jab_pend_q) begin
                rx_er_q         <= 1'b1;
                rx_packet_end_q <= 1'b1;
                rx_dv_q         <= 1'b0;
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (!idle_line && irx_center_sample) begin
                        state_q    <= StPreamble;
                        pre_cnt_q  <= PreW'(1);
                        last_bit_q <= inrz_data;
                    end
                end
                StPreamble: begin
                    if (idle_line) begin
                        state_q <= StIdle;
                    end else if (irx_center_sample) begin
                        last_bit_q <= inrz_data;
                        if (inrz_data != last_bit_q) begin
                            pre_cnt_q <= pre_cnt_q + PreW'(1);
                            if (pre_cnt_q == PreLast) begin
                                sfd_timeout_q <= 1'b1;
                                missed_sfd_q  <= 1'b1;
                                state_q       <= StWaitIdle;
                                if (sfd_miss_cnt_q != '1) begin
                                    sfd_miss_cnt_q <= sfd_miss_cnt_q + CNT_W'(1);
                                end
                            end
                        end else if (inrz_data && (pre_cnt_q >= PreMin)) begin
                            state_q   <= StData;
                            rx_dv_q   <= 1'b1;
                            shreg_q   <= '0;
                            bit_cnt_q <= '0;
                            nib_cnt_q <= '0;
                        end else begin
                            // "00", or "11" arriving before enough preamble: restart the count.
                            pre_cnt_q <= PreW'(1);
                        end
                    end
                end
                StData: begin
                    if (idle_line) begin
                        state_q         <= StIdle;
                        rx_dv_q         <= 1'b0;
                        rx_packet_end_q <= 1'b1;
                        if (bit_cnt_q == 2'd0) begin
                            if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
                        end else begin
                            // Dribble bits: partial nibble is dropped and flagged.
                            rx_er_q <= 1'b1;
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
                        end
                    end else if (irx_center_sample) begin
                        shreg_q   <= {inrz_data, shreg_q[2:1]};
                        bit_cnt_q <= bit_cnt_q + 2'd1;
                        if (bit_cnt_q == 2'd3) begin
                            rx_nibble_q       <= {inrz_data, shreg_q};
                            rx_nibble_valid_q <= 1'b1;
                            nib_cnt_q         <= nib_cnt_q + NibW'(1);
                            if (nib_cnt_q == NibLast) begin
                                jab_pend_q <= 1'b1;
                                state_q    <= StWaitIdle;
                            end
                        end
                    end
                end
                StWaitIdle: begin
                    if (idle_line) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Placed last so the clear overrides any same-cycle increment.
            if (reset_all_pkt_cntrs) begin
                pkt_cnt_q      <= '0;
                err_cnt_q      <= '0;
                sfd_miss_cnt_q <= '0;
                missed_sfd_q   <= 1'b0;
            end
        end
    end

    assign rx_nibble       = rx_nibble_q;
    assign rx_nibble_valid = rx_nibble_valid_q;
    assign rx_dv           = rx_dv_q;
    assign rx_er           = rx_er_q;
    assign rx_packet_end   = rx_packet_end_q;
    assign sfd_timeout     = sfd_timeout_q;
    assign missed_sfd_flag = missed_sfd_q;
    assign rx_state        = state_q;
    assign pkt_cnt         = pkt_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign sfd_miss_cnt    = sfd_miss_cnt_q;

endmodule

// File: tb/tb_manchester_serial_to_nibble_sm.sv
// Bench for manchester_serial_to_nibble_sm: nibble scoreboard plus per-scenario tasks.
module tb_manchester_serial_to_nibble_sm;

    localparam int unsigned MinPre  = 16;
    localparam int unsigned Timeout = 256;
    localparam int unsigned MaxNib  = 8;
    localparam int unsigned CntW    = 4;
    localparam int BitCyc = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic strobe = 1'b0;
    logic nrz = 1'b0;
    logic idle = 1'b0;
    logic clr = 1'b0;
    logic [3:0] rx_nibble;
    logic rx_nibble_valid, rx_dv, rx_er, rx_packet_end, sfd_timeout, missed_sfd_flag;
    logic [2:0] rx_state;
    logic [CntW-1:0] pkt_cnt, err_cnt, sfd_miss_cnt;

    manchester_serial_to_nibble_sm #(
        .MIN_PREAMBLE_BITS(MinPre),
        .SFD_TIMEOUT_BITS (Timeout),
        .MAX_NIBBLES      (MaxNib),
        .CNT_W            (CntW)
    ) dut (
        .clk16x             (clk),
        .reset              (reset),
        .irx_center_sample  (strobe),
        .inrz_data          (nrz),
        .idle_line          (idle),
        .reset_all_pkt_cntrs(clr),
        .rx_nibble          (rx_nibble),
        .rx_nibble_valid    (rx_nibble_valid),
        .rx_dv              (rx_dv),
        .rx_er              (rx_er),
        .rx_packet_end      (rx_packet_end),
        .sfd_timeout        (sfd_timeout),
        .missed_sfd_flag    (missed_sfd_flag),
        .rx_state           (rx_state),
        .pkt_cnt            (pkt_cnt),
        .err_cnt            (err_cnt),
        .sfd_miss_cnt       (sfd_miss_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_nib;
    int cyc = 0;
    int nib_seen = 0, er_seen = 0, pend_seen = 0, sto_seen = 0;
    int last_nib_cyc = 0, er_cyc = 0, dv_fall_cyc = 0;
    logic dv_prev = 1'b0;

    // Scoreboard monitor: pops expected nibbles as the DUT emits them.
    always @(negedge clk) begin
        cyc++;
        if (rx_nibble_valid) begin
            nib_seen++;
            last_nib_cyc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL nibble_unexpected: got %h, required no nibble", rx_nibble);
            end else begin
                exp_nib = exp_q.pop_front();
                if (rx_nibble !== exp_nib) begin
                    n_mis++;
                    $display("FAIL nibble_value: got %h, required %h", rx_nibble, exp_nib);
                end
            end
            n_cmp++;
            if (rx_dv !== 1'b1) begin
                n_mis++;
                $display("FAIL dv_with_nibble: got %b, required 1", rx_dv);
            end
        end
        if (rx_er) begin er_seen++; er_cyc = cyc; end
        if (rx_packet_end) pend_seen++;
        if (sfd_timeout) sto_seen++;
        if (dv_prev && !rx_dv) dv_fall_cyc = cyc;
        dv_prev = rx_dv;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        nrz = b;
        strobe = 1'b1;
        tick(1);
        strobe = 1'b0;
        tick(BitCyc - 1);
    endtask

    task automatic send_preamble(input int n);
        for (int i = 0; i < n; i++) send_bit((i % 2) == 0);
    endtask

    task automatic send_sfd();
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic send_nib(input logic [3:0] v, input logic push);
        if (push) exp_q.push_back(v);
        for (int i = 0; i < 4; i++) send_bit(v[i]);
    endtask

    task automatic idle_for(input int n);
        idle = 1'b1;
        tick(n);
        idle = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        tick(3);
        n_cmp++;
        if ({rx_nibble, rx_nibble_valid, rx_dv, rx_er, rx_packet_end, sfd_timeout,
             missed_sfd_flag, rx_state} !== 13'd0) begin
            n_mis++;
            $display("FAIL reset_outputs: got %h, required 0", {rx_nibble, rx_nibble_valid,
                     rx_dv, rx_er, rx_packet_end, sfd_timeout, missed_sfd_flag, rx_state});
        end
        n_cmp++;
        if ({pkt_cnt, err_cnt, sfd_miss_cnt} !== '0) begin
            n_mis++;
            $display("FAIL reset_counters: got %h/%h/%h, required 0/0/0",
                     pkt_cnt, err_cnt, sfd_miss_cnt);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic_frame();
        int p0 = pend_seen, e0 = er_seen, n0 = nib_seen;
        send_preamble(16);
        send_sfd();
        n_cmp++;
        if (rx_dv !== 1'b1) begin n_mis++; $display("FAIL basic_dv: got %b, required 1", rx_dv); end
        send_nib(4'h5, 1'b1); send_nib(4'hA, 1'b1);
        send_nib(4'hC, 1'b1); send_nib(4'h3, 1'b1);
        idle_for(4);
        n_cmp++;
        if (nib_seen - n0 != 4) begin
            n_mis++; $display("FAIL basic_nibbles: got %0d, required 4", nib_seen - n0);
        end
        n_cmp++;
        if (pend_seen - p0 != 1 || er_seen - e0 != 0) begin
            n_mis++; $display("FAIL basic_end_er: got end=%0d er=%0d, required end=1 er=0",
                              pend_seen - p0, er_seen - e0);
        end
        n_cmp++;
        if (pkt_cnt !== 4'd1 || rx_dv !== 1'b0) begin
            n_mis++; $display("FAIL basic_pkt_cnt: got %0d dv=%b, required 1 dv=0", pkt_cnt, rx_dv);
        end
    endtask

    task automatic test_short_preamble();
        int n0 = nib_seen;
        send_preamble(8);
        send_sfd();
        n_cmp++;
        if (rx_dv !== 1'b0 || rx_state !== 3'd1) begin
            n_mis++; $display("FAIL short_sfd_ignored: got dv=%b st=%0d, required dv=0 st=1",
                              rx_dv, rx_state);
        end
        send_preamble(16);
        send_sfd();
        send_nib(4'hF, 1'b1); send_nib(4'h0, 1'b1);
        idle_for(4);
        n_cmp++;
        if (nib_seen - n0 != 2 || pkt_cnt !== 4'd2) begin
            n_mis++; $display("FAIL short_frame: got nib=%0d pkt=%0d, required nib=2 pkt=2",
                              nib_seen - n0, pkt_cnt);
        end
    endtask

    task automatic test_sfd_timeout();
        int s0 = sto_seen;
        send_preamble(255);
        n_cmp++;
        if (sto_seen - s0 != 0) begin
            n_mis++; $display("FAIL timeout_early: got %0d pulses, required 0", sto_seen - s0);
        end
        send_bit(1'b0);
        n_cmp++;
        if (sto_seen - s0 != 1 || missed_sfd_flag !== 1'b1 || sfd_miss_cnt !== 4'd1) begin
            n_mis++; $display("FAIL timeout_pulse: got pulses=%0d flag=%b cnt=%0d, required 1/1/1",
                              sto_seen - s0, missed_sfd_flag, sfd_miss_cnt);
        end
        send_preamble(16);
        send_sfd();
        send_nib(4'h7, 1'b0);
        n_cmp++;
        if (rx_dv !== 1'b0 || rx_state !== 3'd3) begin
            n_mis++; $display("FAIL timeout_wait_idle: got dv=%b st=%0d, required dv=0 st=3",
                              rx_dv, rx_state);
        end
        idle_for(4);
        send_preamble(16);
        send_sfd();
        send_nib(4'hA, 1'b1); send_nib(4'h5, 1'b1);
        idle_for(4);
        n_cmp++;
        if (pkt_cnt !== 4'd3) begin
            n_mis++; $display("FAIL timeout_recover: got pkt=%0d, required 3", pkt_cnt);
        end
    endtask

    task automatic test_dribble();
        int n0 = nib_seen, e0 = er_seen, p0 = pend_seen;
        send_preamble(16);
        send_sfd();
        send_nib(4'hB, 1'b1);
        send_bit(1'b0); send_bit(1'b1);
        idle_for(4);
        n_cmp++;
        if (nib_seen - n0 != 1 || er_seen - e0 != 1 || pend_seen - p0 != 1) begin
            n_mis++; $display("FAIL dribble_strobes: got nib=%0d er=%0d end=%0d, required 1/1/1",
                              nib_seen - n0, er_seen - e0, pend_seen - p0);
        end
        n_cmp++;
        if (err_cnt !== 4'd1 || pkt_cnt !== 4'd3) begin
            n_mis++; $display("FAIL dribble_counters: got err=%0d pkt=%0d, required err=1 pkt=3",
                              err_cnt, pkt_cnt);
        end
    endtask

    task automatic test_jabber();
        int n0 = nib_seen, e0 = er_seen, p0 = pend_seen;
        send_preamble(16);
        send_sfd();
        for (int i = 0; i < 10; i++) send_nib(4'(i + 1), i < 8);
        n_cmp++;
        if (nib_seen - n0 != 8 || er_seen - e0 != 1 || pend_seen - p0 != 1) begin
            n_mis++; $display("FAIL jabber_strobes: got nib=%0d er=%0d end=%0d, required 8/1/1",
                              nib_seen - n0, er_seen - e0, pend_seen - p0);
        end
        n_cmp++;
        if (er_cyc != last_nib_cyc + 1 || dv_fall_cyc != last_nib_cyc + 1) begin
            n_mis++; $display("FAIL jabber_timing: got er@%0d dvfall@%0d, required both @%0d",
                              er_cyc, dv_fall_cyc, last_nib_cyc + 1);
        end
        n_cmp++;
        if (rx_state !== 3'd3 || err_cnt !== 4'd2) begin
            n_mis++; $display("FAIL jabber_state: got st=%0d err=%0d, required st=3 err=2",
                              rx_state, err_cnt);
        end
        idle_for(4);
    endtask

    task automatic test_err_saturation();
        int e0 = er_seen;
        for (int i = 0; i < 14; i++) begin
            send_preamble(16);
            send_sfd();
            send_bit(1'b1);
            idle_for(2);
        end
        n_cmp++;
        if (err_cnt !== 4'hF || er_seen - e0 != 14) begin
            n_mis++; $display("FAIL err_saturation: got err=%0d er=%0d, required err=15 er=14",
                              err_cnt, er_seen - e0);
        end
    endtask

    task automatic test_clear_counters();
        send_preamble(16);
        send_sfd();
        send_nib(4'h6, 1'b1); send_nib(4'h9, 1'b1);
        idle = 1'b1;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        n_cmp++;
        if ({pkt_cnt, err_cnt, sfd_miss_cnt} !== '0 || missed_sfd_flag !== 1'b0) begin
            n_mis++; $display("FAIL clear_counters: got %h/%h/%h flag=%b, required 0/0/0 flag=0",
                              pkt_cnt, err_cnt, sfd_miss_cnt, missed_sfd_flag);
        end
        n_cmp++;
        if (rx_packet_end !== 1'b1 || rx_dv !== 1'b0) begin
            n_mis++; $display("FAIL clear_end_strobe: got end=%b dv=%b, required end=1 dv=0",
                              rx_packet_end, rx_dv);
        end
        tick(3);
        idle = 1'b0;
        tick(2);
        send_preamble(16);
        send_sfd();
        send_nib(4'h1, 1'b1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        n_cmp++;
        if (rx_dv !== 1'b1 || rx_state !== 3'd2) begin
            n_mis++; $display("FAIL clear_keeps_state: got dv=%b st=%0d, required dv=1 st=2",
                              rx_dv, rx_state);
        end
        send_nib(4'hE, 1'b1);
        idle_for(4);
        n_cmp++;
        if (pkt_cnt !== 4'd1) begin
            n_mis++; $display("FAIL clear_then_count: got pkt=%0d, required 1", pkt_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        int e0, p0;
        send_preamble(16);
        send_sfd();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        e0 = er_seen;
        p0 = pend_seen;
        reset = 1'b1;
        tick(1);
        n_cmp++;
        if (rx_dv !== 1'b0 || rx_state !== 3'd0 || pkt_cnt !== '0) begin
            n_mis++; $display("FAIL midframe_reset: got dv=%b st=%0d pkt=%0d, required 0/0/0",
                              rx_dv, rx_state, pkt_cnt);
        end
        reset = 1'b0;
        tick(4);
        n_cmp++;
        if (er_seen != e0 || pend_seen != p0) begin
            n_mis++; $display("FAIL midframe_no_strobes: got er=%0d end=%0d, required 0/0",
                              er_seen - e0, pend_seen - p0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_short_preamble();
        test_sfd_timeout();
        test_dribble();
        test_jabber();
        test_err_saturation();
        test_clear_counters();
        test_reset_midframe();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++; $display("FAIL scoreboard_drain: got %0d left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
